// File: rtl/router_pkg.sv
// Shared definitions for the 3-port mesh router.
//   P_LOCAL/P_X/P_Y : port indices (0 = local, 1 = x link, 2 = y link)
//   NPORT           : port count, fixed by the mesh topology
//   route_port()    : dimension-order route of a head flit (x first, then y)
//   rr_next()       : round-robin successor modulo NPORT
package router_pkg;

    localparam int P_LOCAL = 0;
    localparam int P_X     = 1;
    localparam int P_Y     = 2;
    localparam int NPORT   = 3;

    // Coordinates are zero-extended to this width before comparison, so any
    // coordinate width up to CW_MAX can share the one routing function.
    localparam int CW_MAX  = 8;

    typedef logic [1:0] port_t;

    function automatic port_t route_port(input logic [CW_MAX-1:0] dst_x,
                                         input logic [CW_MAX-1:0] dst_y,
                                         input logic [CW_MAX-1:0] cur_x,
                                         input logic [CW_MAX-1:0] cur_y);
        port_t p;
        if (dst_x != cur_x)      p = port_t'(P_X);
        else if (dst_y != cur_y) p = port_t'(P_Y);
        else                     p = port_t'(P_LOCAL);
        return p;
    endfunction

    function automatic port_t rr_next(input port_t p);
        return (p == port_t'(NPORT-1)) ? port_t'(0) : port_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Synchronous FIFO for one router input.
// Ports: clk, rst_n (async active-low); push/din write side (ignored when
// full); pop/dout read side (dout is the current head, ignored when empty);
// full, empty status.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// equal except for the wrap bit mean full.
module router_fifo #(
    parameter int WD    = 40,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [WD-1:0] din,
    output logic          full,
    input  logic          pop,
    output logic [WD-1:0] dout,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [WD-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push while full is dropped even if a pop frees a slot this cycle;
    // the upstream ready already told the sender to hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_router_rr.sv
// 3-port (local/x/y) mesh router with per-input FIFOs, dimension-order
// routing and a round-robin arbiter plus output register per output port.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cur_x, cur_y        this node's coordinates (quasi-static)
//   in_data/in_valid    input flits, port p at [p*WD +: WD]
//   in_ready            input FIFO not full
//   out_data/out_valid  registered output flits
//   out_ready           downstream accept
// Optional build macro ROUTER_STATS_EN adds:
//   stat_flits          per-output saturating transfer counters (16b each)
//   stat_conflict       saturating count of cycles where an open output saw
//                       two or more requesters
// A flit presented on an input is written into its FIFO at the next edge and
// reaches the output register one edge later when uncontended.
module noc_router_rr
    import router_pkg::*;
#(
    parameter int WD    = 40,
    parameter int CW    = 2,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CW-1:0]       cur_x,
    input  logic [CW-1:0]       cur_y,
    input  logic [NPORT*WD-1:0] in_data,
    input  logic [NPORT-1:0]    in_valid,
    output logic [NPORT-1:0]    in_ready,
    output logic [NPORT*WD-1:0] out_data,
    output logic [NPORT-1:0]    out_valid,
    input  logic [NPORT-1:0]    out_ready
`ifdef ROUTER_STATS_EN
    ,
    output logic [NPORT*16-1:0] stat_flits,
    output logic [15:0]         stat_conflict
`endif
);

    logic [NPORT-1:0]            fifo_full, fifo_empty, fifo_pop;
    logic [NPORT-1:0][WD-1:0]    head;
    port_t                       req_port [NPORT];
    logic [NPORT-1:0][NPORT-1:0] gnt_all;   // [output][input]
`ifdef ROUTER_STATS_EN
    logic [NPORT-1:0]            conflict_o;
`endif

    // ---------------- inputs: FIFO + route of the head flit ----------------
    for (genvar i = 0; i < NPORT; i++) begin : g_in
        router_fifo #(.WD(WD), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[i] & ~fifo_full[i]),
            .din   (in_data[i*WD +: WD]),
            .full  (fifo_full[i]),
            .pop   (fifo_pop[i]),
            .dout  (head[i]),
            .empty (fifo_empty[i])
        );

        assign in_ready[i] = ~fifo_full[i];
        assign req_port[i] = route_port(CW_MAX'(head[i][WD-1 -: CW]),
                                        CW_MAX'(head[i][WD-CW-1 -: CW]),
                                        CW_MAX'(cur_x), CW_MAX'(cur_y));
    end

    // Every input targets exactly one output, so at most one grant per input.
    always_comb begin
        fifo_pop = '0;
        for (int o = 0; o < NPORT; o++) fifo_pop |= gnt_all[o];
    end

    // ---------------- outputs: arbiter + output register -------------------
    for (genvar o = 0; o < NPORT; o++) begin : g_out
        logic [NPORT-1:0] req, gnt;
        port_t            rr, sel, cand;
        logic             hit, open_o, vld_q;
        logic [WD-1:0]    data_q;

        // Arbitration only matters when the register can take a new flit.
        assign open_o = ~vld_q | out_ready[o];

        always_comb begin
            for (int i = 0; i < NPORT; i++)
                req[i] = ~fifo_empty[i] && (req_port[i] == port_t'(o));
        end

        // First requester at or after rr, wrapping modulo NPORT.
        always_comb begin
            gnt  = '0;
            sel  = rr;
            cand = rr;
            hit  = 1'b0;
            for (int k = 0; k < NPORT; k++) begin
                cand = port_t'((int'(rr) + k) % NPORT);
                if (!hit && req[cand]) begin
                    hit = 1'b1;
                    sel = cand;
                end
            end
            if (hit && open_o) gnt[sel] = 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= 1'b0;
                rr     <= '0;
            end else if (open_o) begin
                if (hit) begin
                    data_q <= head[sel];
                    vld_q  <= 1'b1;
                    rr     <= rr_next(sel);
                end else begin
                    vld_q  <= 1'b0;
                end
            end
        end

        assign gnt_all[o]            = gnt;
        assign out_data[o*WD +: WD]  = data_q;
        assign out_valid[o]          = vld_q;

`ifdef ROUTER_STATS_EN
        logic [15:0] flits_q;

        assign conflict_o[o] = open_o && ($countones(req) >= 2);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                        flits_q <= '0;
            else if (vld_q && out_ready[o] && flits_q != 16'hFFFF) flits_q <= flits_q + 16'd1;
        end

        assign stat_flits[o*16 +: 16] = flits_q;
`endif
    end

`ifdef ROUTER_STATS_EN
    // Counts cycles, not output-conflicts: several contended outputs in one
    // cycle add one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    stat_conflict <= '0;
        else if (|conflict_o && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
    end
`endif

endmodule

// File: tb/tb_noc_router_rr.sv
// Bench for noc_router_rr: a negedge monitor records every accepted input
// flit into an expected queue keyed by (routed output, source input) and
// pops/compares on every output transfer. Flits carry their source port and
// a sequence number, so loss, duplication, misrouting and reordering within
// a source/destination pair are all caught. Directed sequences cover reset,
// latency, round-robin alternation, backpressure/full and mid-stream reset.
module tb_noc_router_rr;

    localparam int WD      = 40;
    localparam int CW      = 2;
    localparam int DEPTH   = 4;
    localparam int NP      = 3;
    localparam int SRC_LSB = WD - 2*CW - 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CW-1:0]       cur_x, cur_y;
    logic [NP*WD-1:0]    in_data;
    logic [NP-1:0]       in_valid, in_ready;
    logic [NP*WD-1:0]    out_data;
    logic [NP-1:0]       out_valid, out_ready;
`ifdef ROUTER_STATS_EN
    logic [NP*16-1:0]    stat_flits;
    logic [15:0]         stat_conflict;
`endif

    noc_router_rr #(.WD(WD), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROUTER_STATS_EN
        ,
        .stat_flits    (stat_flits),
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [WD-1:0] exp_q [NP*NP][$];   // index = out*NP + src
    int  deliv [NP];
    int  ytrace [$];
    bit  trace_en = 1'b0;
    logic [15:0] seq = 16'd0;

    task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference routing straight from the x-then-y rule.
    function automatic int ref_route(input logic [WD-1:0] f);
        if (f[WD-1 -: CW] != cur_x) return 1;
        if (f[WD-CW-1 -: CW] != cur_y) return 2;
        return 0;
    endfunction

    function automatic logic [WD-1:0] mk(input int src, input int dx, input int dy);
        logic [WD-1:0] f;
        f = WD'({$urandom, $urandom});
        f[WD-1 -: CW]      = CW'(dx);
        f[WD-CW-1 -: CW]   = CW'(dy);
        f[SRC_LSB +: 2]    = 2'(src);
        f[SRC_LSB-1 -: 16] = seq;
        seq = seq + 16'd1;
        return f;
    endfunction

    function automatic int q_total();
        int n = 0;
        for (int k = 0; k < NP*NP; k++) n += exp_q[k].size();
        return n;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NP*NP; k++) exp_q[k].delete();
        for (int o = 0; o < NP; o++) deliv[o] = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [NP-1:0]  hold = '0;
    logic [WD-1:0]  hold_data [NP];

    always @(negedge clk) begin
        logic [WD-1:0] f, e;
        int s;
        if (!rst_n) begin
            hold = '0;
        end else begin
            for (int i = 0; i < NP; i++)
                if (in_valid[i] && in_ready[i]) begin
                    f = in_data[i*WD +: WD];
                    exp_q[ref_route(f)*NP + i].push_back(f);
                end
            for (int o = 0; o < NP; o++) begin
                f = out_data[o*WD +: WD];
                if (hold[o])
                    check(out_valid[o] && f == hold_data[o], "hold_stable", f, hold_data[o]);
                if (out_valid[o] && out_ready[o]) begin
                    s = int'(f[SRC_LSB +: 2]);
                    if (s >= NP || exp_q[o*NP + s].size() == 0) begin
                        check(1'b0, "unexpected_flit", f, 0);
                    end else begin
                        e = exp_q[o*NP + s].pop_front();
                        check(f == e, "flit_data", f, e);
                    end
                    deliv[o]++;
                    if (trace_en && o == 2) ytrace.push_back(s);
                end
                hold[o]      = out_valid[o] && !out_ready[o];
                hold_data[o] = f;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int ncyc);
        logic [NP-1:0] fired = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < NP; i++)
                if (!in_valid[i] || fired[i]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        in_valid[i] = 1'b1;
                        in_data[i*WD +: WD] = mk(i, $urandom_range(0, 3), $urandom_range(0, 3));
                    end else begin
                        in_valid[i] = 1'b0;
                    end
                end
            for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fired = in_valid & in_ready;
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = '0;
        out_ready = '1;
        while (q_total() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check(q_total() == 0, "drain_empty", q_total(), 0);
    endtask

    // ---------------- main sequence ----------------
    logic [WD-1:0] f0;
    logic [WD-1:0] bp [6];

    initial begin
        logic [NP-1:0] fired;
        int sent, n;
        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = '0;
        cur_x = 2'd2; cur_y = 2'd1;
        clear_model();

        // Reset state
        #3;
        check(out_valid == '0, "rst_assert_out_valid", out_valid, 0);
        do_reset();
        check(in_ready == 3'b111, "rst_in_ready", in_ready, 3'b111);
        check(out_valid == '0, "rst_out_valid", out_valid, 0);
        check(out_data == '0, "rst_out_data", out_data, 0);

        // Latency: local -> x, two edges
        out_ready = '1;
        f0 = mk(0, 3, 1);
        in_valid = 3'b001;
        in_data[0 +: WD] = f0;
        @(posedge clk); #1;
        in_valid = '0;
        check(out_valid == '0, "lat_not_early", out_valid, 0);
        @(posedge clk); #1;
        check(out_valid == 3'b010, "lat_valid", out_valid, 3'b010);
        check(out_data[WD +: WD] == f0, "lat_data", out_data[WD +: WD], f0);
        drain();

        // Round-robin: x-in and y-in both to y output
        do_reset();
        out_ready = '1;
        ytrace.delete();
        trace_en = 1'b1;
        fired = '0;
        n = 0;
        while (ytrace.size() < 8 && n < 40) begin
            if (!in_valid[1] || fired[1]) begin in_valid[1] = 1'b1; in_data[WD +: WD]   = mk(1, 2, 3); end
            if (!in_valid[2] || fired[2]) begin in_valid[2] = 1'b1; in_data[2*WD +: WD] = mk(2, 2, 0); end
            @(negedge clk);
            fired = in_valid & in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = '0;
        trace_en = 1'b0;
        check(ytrace.size() >= 8, "alt_count", ytrace.size(), 8);
        for (int k = 0; k < 8 && k < ytrace.size(); k++)
            check(ytrace[k] == ((k % 2 == 0) ? 1 : 2), "alt_order", ytrace[k], (k % 2 == 0) ? 1 : 2);
        drain();

        // Backpressure on local output, 6 flits from input 1
        do_reset();
        out_ready = 3'b110;
        for (int k = 0; k < 6; k++) bp[k] = mk(1, 2, 1);
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid[1] = (sent < 6);
            if (sent < 6) in_data[WD +: WD] = bp[sent];
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) sent++;
            @(posedge clk); #1;
            if (c >= 1)
                check(out_valid[0] && out_data[0 +: WD] == bp[0], "bp_hold", out_data[0 +: WD], bp[0]);
        end
        check(sent == DEPTH + 1, "bp_accepts", sent, DEPTH + 1);
        check(in_ready[1] == 1'b0, "bp_full", in_ready[1], 0);
        out_ready = '1;
        @(negedge clk);
        check(in_ready[1] == 1'b0, "full_push_pop_rejected", in_ready[1], 0);
        @(posedge clk); #1;
        n = 0;
        while (deliv[0] < 6 && n < 20) begin
            in_valid[1] = (sent < 6);
            if (sent < 6) in_data[WD +: WD] = bp[sent];
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) sent++;
            @(posedge clk); #1;
            n++;
        end
        check(deliv[0] == 6, "bp_delivered", deliv[0], 6);
        drain();

        // Mid-stream reset, asserted off-edge
        run_random(8);
        out_ready = '0;
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        in_valid = '0;
        clear_model();
        #1;
        check(out_valid == '0, "midrst_out_valid", out_valid, 0);
        check(out_data == '0, "midrst_out_data", out_data, 0);
        check(in_ready == 3'b111, "midrst_in_ready", in_ready, 3'b111);
        out_ready = '1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check(out_valid == '0, "no_stale", out_valid, 0);
        end

        // Random traffic, two node positions
        run_random(600);
        drain();
        cur_x = 2'd0; cur_y = 2'd3;
        run_random(400);
        drain();

`ifdef ROUTER_STATS_EN
        for (int o = 0; o < NP; o++)
            check(stat_flits[o*16 +: 16] == 16'(deliv[o]), "stat_flits", stat_flits[o*16 +: 16], deliv[o]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
